// File: rtl/intan_fifo_writer.sv
// Write-side responder for the Intan sample FIFO pair.
//
// When the downstream reader raises fs_read, this block writes one frame into
// the high-byte/low-byte FIFO pair. A frame is a header word {HEAD_TAG, frame_cnt}
// followed by one sample word per channel from the converter stream. It then
// raises fd_read until fs_read drops. Dropping fs_read mid-frame aborts the frame
// and sets the sticky err flag.
//
// Ports:
//   clk        FIFO write clock
//   rst        asynchronous active-high reset
//   dev_kind   channels per frame (00:16, 01:32, 10:64, 11:128), latched at frame start
//   fs_read    frame request level from the reader
//   fd_read    frame done, high while in DONE
//   smp_d      sample word from the converter
//   smp_valid  sample valid
//   smp_ready  sample accepted when smp_valid & smp_ready
//   fifo_txd   write data, [15:8] to FIFO1, [7:0] to FIFO0
//   fifo_txen  write enables {FIFO1, FIFO0}, always both or neither
//   fifo_full  full flags {FIFO1, FIFO0}
//   frame_cnt  completed-frame counter, wraps
//   err        sticky abort flag
module intan_fifo_writer #(
  parameter logic [7:0]  HEAD_TAG = 8'hA5,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       dev_kind,
  input  logic             fs_read,
  output logic             fd_read,
  input  logic [15:0]      smp_d,
  input  logic             smp_valid,
  output logic             smp_ready,
  output logic [15:0]      fifo_txd,
  output logic [1:0]       fifo_txen,
  input  logic [1:0]       fifo_full,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err
);

  localparam logic [3:0] StIdle = 4'b0001;
  localparam logic [3:0] StHead = 4'b0010;
  localparam logic [3:0] StData = 4'b0100;
  localparam logic [3:0] StDone = 4'b1000;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] ch_cnt_q, ch_cnt_d;
  logic [CNT_W-1:0] ch_num_q, ch_num_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ch_cnt_inc;
  logic             wr_ok;

  // One full flag stalls both byte lanes so the pair stays word-aligned.
  assign wr_ok      = ~|fifo_full;
  assign ch_cnt_inc = ch_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    ch_cnt_d    = ch_cnt_q;
    ch_num_d    = ch_num_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;
    fd_read     = 1'b0;
    smp_ready   = 1'b0;
    fifo_txen   = 2'b00;
    fifo_txd    = 16'h0000;

    unique case (state_q)
      StIdle: begin
        if (fs_read) begin
          ch_num_d = CNT_W'(16) << dev_kind;
          ch_cnt_d = '0;
          state_d  = StHead;
        end
      end
      StHead: begin
        if (!fs_read) begin
          // Abort: nothing written this cycle.
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (wr_ok) begin
          fifo_txen = 2'b11;
          fifo_txd  = {HEAD_TAG, frame_cnt_q};
          state_d   = StData;
        end
      end
      StData: begin
        if (!fs_read) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          smp_ready = wr_ok;
          if (smp_valid && wr_ok) begin
            fifo_txen = 2'b11;
            fifo_txd  = smp_d;
            ch_cnt_d  = ch_cnt_inc;
            if (ch_cnt_inc == ch_num_q) begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        fd_read = 1'b1;
        if (!fs_read) begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ch_cnt_q    <= '0;
      ch_num_q    <= CNT_W'(16);
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_cnt_q    <= ch_cnt_d;
      ch_num_q    <= ch_num_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_intan_fifo_writer.sv
// Bench for intan_fifo_writer: randomized frame requests, a scoreboard of
// expected FIFO words built from the frame rules, and a negedge write monitor.
module tb_intan_fifo_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  dev_kind;
  logic        fs_read;
  logic        fd_read;
  logic [15:0] smp_d;
  logic        smp_valid;
  logic        smp_ready;
  logic [15:0] fifo_txd;
  logic [1:0]  fifo_txen;
  logic [1:0]  fifo_full;
  logic [7:0]  frame_cnt;
  logic        err;

  intan_fifo_writer dut (
    .clk       (clk),
    .rst       (rst),
    .dev_kind  (dev_kind),
    .fs_read   (fs_read),
    .fd_read   (fd_read),
    .smp_d     (smp_d),
    .smp_valid (smp_valid),
    .smp_ready (smp_ready),
    .fifo_txd  (fifo_txd),
    .fifo_txen (fifo_txen),
    .fifo_full (fifo_full),
    .frame_cnt (frame_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  logic [15:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          idx;
  logic [15:0] base;
  bit          acc;
  logic [7:0]  model_fc;
  bit          model_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Monitor: every write must match the next expected word; idle data must be zero.
  always @(negedge clk) begin
    logic [15:0] w;
    n_cmp++;
    if (fifo_txen == 2'b00) begin
      if (fifo_txd !== 16'h0000) begin
        n_fail++;
        $display("FAIL txd_idle: got %h, required 0000", fifo_txd);
      end
    end else if (fifo_txen == 2'b11) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got %h, required no write", fifo_txd);
      end else begin
        w = exp_q.pop_front();
        if (fifo_txd !== w) begin
          n_fail++;
          $display("FAIL write_data: got %h, required %h", fifo_txd, w);
        end
      end
    end else begin
      n_fail++;
      $display("FAIL txen_split: got %b, required 00 or 11", fifo_txen);
    end
  end

  // Settle, optionally check stall behaviour, clock once; producer advances on accept.
  task automatic step(input bit chk_stall);
    #1;
    if (chk_stall && fifo_full != 2'b00) begin
      check("stall_txen", 32'(fifo_txen), 32'd0);
      check("stall_ready", 32'(smp_ready), 32'd0);
    end
    acc = smp_valid && smp_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      idx++;
      smp_d = base + 16'(idx);
    end
  endtask

  // One frame request. stop_at >= 0 ends the frame early after that many samples,
  // aborting it when abort=1 or leaving it mid-DATA otherwise.
  task automatic run_frame(input logic [1:0] kind, input logic [15:0] b, input int vprob,
                           input int fprob, input int win_s, input int win_l,
                           input logic [1:0] win_v, input int stop_at, input bit abort,
                           input bit toggle);
    int n_ch;
    int n_exp;
    bit ended;
    n_ch  = 16 << kind;
    n_exp = (stop_at >= 0) ? stop_at : n_ch;
    ended = 1'b0;
    exp_q.push_back({8'hA5, model_fc});
    for (int i = 0; i < n_exp; i++) exp_q.push_back(b + 16'(i));
    base     = b;
    idx      = 0;
    smp_d    = b;
    dev_kind = kind;
    fs_read  = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (idx == n_exp) begin
        ended = 1'b1;
        break;
      end
      smp_valid = ($urandom_range(99) < vprob);
      if (cyc >= win_s && cyc < win_s + win_l) fifo_full = win_v;
      else fifo_full = ($urandom_range(99) < fprob) ? 2'($urandom_range(3, 1)) : 2'b00;
      if (toggle && cyc > 0) dev_kind = 2'($urandom);
      check("fd_early", 32'(fd_read), 32'd0);
      step(1'b1);
    end
    if (!ended) begin
      n_cmp++;
      n_fail++;
      $display("FAIL frame_timeout: got %0d samples, required %0d", idx, n_exp);
      return;
    end
    if (stop_at < 0) begin
      check("fd_done", 32'(fd_read), 32'd1);
      for (int k = $urandom_range(2); k > 0; k--) begin
        smp_valid = $urandom_range(1);
        step(1'b0);
        check("fd_hold", 32'(fd_read), 32'd1);
      end
      check("frame_drained", 32'(exp_q.size()), 32'd0);
      fs_read = 1'b0;
      step(1'b0);
      model_fc++;
      check("frame_cnt", 32'(frame_cnt), 32'(model_fc));
      check("fd_clear", 32'(fd_read), 32'd0);
      check("err_state", 32'(err), 32'(model_err));
    end else if (abort) begin
      fs_read   = 1'b0;
      smp_valid = 1'b1;
      step(1'b0);
      model_err = 1'b1;
      check("abort_err", 32'(err), 32'd1);
      check("abort_fd", 32'(fd_read), 32'd0);
      check("abort_fc", 32'(frame_cnt), 32'(model_fc));
      check("abort_ready", 32'(smp_ready), 32'd0);
      check("abort_drained", 32'(exp_q.size()), 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    dev_kind  = 2'b00;
    fs_read   = 1'b0;
    smp_d     = 16'h0000;
    smp_valid = 1'b0;
    fifo_full = 2'b00;
    model_fc  = 8'h00;
    model_err = 1'b0;
    #3;
    check("rst_txen", 32'(fifo_txen), 32'd0);
    check("rst_ready", 32'(smp_ready), 32'd0);
    check("rst_fd", 32'(fd_read), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_fc", 32'(frame_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Basic frame: header A500 then 0100..010F.
    run_frame(2'b00, 16'h0100, 100, 0, -1, 0, 2'b00, -1, 1'b0, 1'b0);
    // Backpressure mid-DATA: FIFO0 full for 3 cycles.
    run_frame(2'b00, 16'h0300, 100, 0, 10, 3, 2'b01, -1, 1'b0, 1'b0);
    // FIFO1 full as the request rises, for 5 cycles.
    run_frame(2'b00, 16'h0400, 100, 0, 0, 5, 2'b10, -1, 1'b0, 1'b0);
    // Randomized frames with stalls and mid-frame dev_kind changes.
    for (int f = 0; f < 6; f++)
      run_frame(2'($urandom_range(2)), 16'($urandom), 60 + $urandom_range(40), 25,
                -1, 0, 2'b00, -1, 1'b0, 1'b1);
    // Abort after 5 samples, then a clean frame reusing the same frame_cnt.
    run_frame(2'b01, 16'h0500, 80, 10, -1, 0, 2'b00, 5, 1'b1, 1'b0);
    run_frame(2'b00, 16'h0600, 100, 0, -1, 0, 2'b00, -1, 1'b0, 1'b0);

    // Async reset mid-DATA, off the clock edge.
    run_frame(2'b01, 16'h0700, 100, 0, -1, 0, 2'b00, 6, 1'b0, 1'b0);
    smp_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("arst_txen", 32'(fifo_txen), 32'd0);
    check("arst_ready", 32'(smp_ready), 32'd0);
    check("arst_fd", 32'(fd_read), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_fc", 32'(frame_cnt), 32'd0);
    exp_q.delete();
    model_fc  = 8'h00;
    model_err = 1'b0;
    fs_read   = 1'b0;
    smp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 256 frames of 128 channels; header low byte and frame_cnt wrap.
    for (int f = 0; f < 256; f++)
      run_frame(2'b11, 16'(f * 7), 100, 0, -1, 0, 2'b00, -1, 1'b0, 1'b1);
    check("fc_wrap", 32'(frame_cnt), 32'(model_fc));
    run_frame(2'b00, 16'h0100, 100, 0, -1, 0, 2'b00, -1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check("final_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/intan_fifo_writer.md
Name: intan_fifo_writer

Overview:
- Write-side responder for the Intan sample FIFO pair. The downstream reader raises fs_read to request one frame.
- The block then writes into the high-byte and low-byte FIFOs:
  - one header word, followed by
  - one sample word per channel, taken from the Intan sample stream.
- It asserts fd_read when the frame is complete.
- It sits inside the intan block, between the SPI sample converter and the dual 8-bit FIFOs (fifoi_txc domain).

Parameters:
- HEAD_TAG, 8'hA5, upper byte of the header word.
- CNT_W, 8, width of the channel counter and the frame counter.

Ports:
- clk  input  1  clock (FIFO write clock).
- rst  input  1  reset; asynchronous, active-high.
- dev_kind  input  2  channels per frame: 00→16, 01→32, 10→64, 11→128. Sampled on IDLE→HEAD.
- fs_read  input  1  frame request, level; held high until fd_read is seen.
- fd_read  output  1  frame done; high in DONE only.
- smp_d  input  16  sample word from the converter.
- smp_valid  input  1  sample valid.
- smp_ready  output  1  sample accepted when smp_valid & smp_ready.
- fifo_txd  output  16  write data; [15:8]→FIFO1, [7:0]→FIFO0.
- fifo_txen  output  2  write enables {FIFO1, FIFO0}; always both or neither.
- fifo_full  input  2  full flags {FIFO1, FIFO0}.
- frame_cnt  output  8  count of completed frames; wraps.
- err  output  1  sticky abort flag; cleared only by rst.

Behaviour:
- States (one-hot): IDLE, HEAD, DATA, DONE.
- Reset (asynchronous, any state, including mid-frame):
  - state=IDLE.
  - fd_read=0, smp_ready=0, fifo_txen=2'b00, fifo_txd=16'h0000, frame_cnt=0, err=0.
  - Channel counter=0, latched channel count=16.
- Define wr_ok = ~|fifo_full. A write occurs only when both FIFOs are not full; a single full flag stalls both.
- fifo_txen and fifo_txd are combinational from state and handshake signals. There is zero latency from acceptance to write enable. fifo_txd=0 whenever fifo_txen=0.
- IDLE:
  - All outputs idle.
  - If fs_read=1: latch the channel count from dev_kind, clear the channel counter, go to HEAD.
- HEAD:
  - If wr_ok: fifo_txen=2'b11, fifo_txd={HEAD_TAG, frame_cnt}, go to DATA.
  - Otherwise hold.
  - smp_ready=0.
- DATA:
  - smp_ready = wr_ok.
  - On smp_valid & smp_ready: fifo_txen=2'b11, fifo_txd=smp_d, channel counter +1.
  - On the accept that makes counter == latched count: go to DONE.
  - smp_valid while ~wr_ok: no accept, no write; the sample is held by the producer (backpressure).
- DONE:
  - fd_read=1; no writes.
  - When fs_read=0: frame_cnt+1 (wraps 255→0), go to IDLE.
  - frame_cnt increments exactly once per completed frame, on DONE exit.
- Abort: fs_read=0 while in HEAD or DATA:
  - Go to IDLE next cycle; no write in that cycle.
  - err←1; frame_cnt unchanged.
  - Words already written remain in the FIFOs; the reader is responsible for flushing them.
- fs_read held high after DONE→IDLE is not possible, since the DONE exit requires fs_read=0. A new request needs fs_read to go low and then high again.
- dev_kind changes mid-frame have no effect; the count latched at the start of the frame is used.
- The channel counter is 8 bits. For 128 channels, the terminal compare is against 8'd128, with no overflow.
- Frame length in words = 1 + channels. For 16 channels, the minimum duration is 17 write cycles, plus 1 IDLE cycle and ≥1 DONE cycle.

Test Plan:
- Basic frame:
  - Stimulus: reset, dev_kind=00, fs_read=1, smp_valid=1 continuously with smp_d=16'h0100+n, FIFOs never full.
  - Required: header 16'hA500, then 16 words 16'h0100..16'h010F on consecutive cycles, each with fifo_txen=11. fd_read=1 the cycle after the last write. Drop fs_read → frame_cnt=1, state IDLE.
- Backpressure:
  - Stimulus: during DATA, assert fifo_full=2'b01 for 3 cycles mid-frame.
  - Required: smp_ready=0 and fifo_txen=00 for those 3 cycles. No sample lost or duplicated; the word sequence stays contiguous.
- Full at header:
  - Stimulus: fifo_full=2'b10 when fs_read rises, clearing after 5 cycles.
  - Required: header written exactly once, in the first cycle with fifo_full=00.
- Channel-count sweep:
  - Stimulus: dev_kind=11, with dev_kind toggled mid-frame.
  - Required: exactly 129 writes (1 header + 128 samples). Run 256 frames: the header low byte wraps FF→00, and frame_cnt wraps to 0.
- Abort:
  - Stimulus: drop fs_read after 5 samples.
  - Required: IDLE next cycle, err=1, frame_cnt unchanged, fd_read never asserted. The next request's header carries the same frame_cnt.
- Async reset:
  - Stimulus: assert rst mid-DATA, not aligned to the clock edge.
  - Required: fifo_txen=00, smp_ready=0, fd_read=0 and err=0 immediately, without waiting for a clock edge. After release, a new frame starts with header 16'hA500.
